// File: rtl/module_branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// execute-stage resolution/redirect and resolved-branch / misprediction perf counters.
module module_branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredictTakenF,
  output logic [31:0] PredictTargetF,
  input  logic        BranchE,
  input  logic        takenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        PredictTakenE,
  input  logic [31:0] PredictTargetE,
  input  logic        FlushE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispred_cnt_q;

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_f;
  logic             hit_e;
  logic             upd;
  logic [1:0]       ctr_e;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;
  logic             unused_pc_low;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign unused_pc_low = ^{PCF[1:0], PCE[1:0]};

  // Lookup: zero-latency read of pre-update contents, no bypass from the execute update.
  always_comb begin
    hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredictTakenF  = rst_n && hit_f && ctr_q[idx_f][1];
    PredictTargetF = PredictTakenF ? target_q[idx_f] : PCF + 32'd4;
  end

  // Resolution: a correctly predicted direction can still redirect on a stale target.
  always_comb begin
    upd         = BranchE && !FlushE;
    MispredictE = upd && ((takenE != PredictTakenE) ||
                          (takenE && PredictTakenE && (PCTargetE != PredictTargetE)));
    CorrectPCE  = takenE ? PCTargetE : PCE + 32'd4;
    hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_e       = ctr_q[idx_e];
    ctr_inc     = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'b01;
    ctr_dec     = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (hit_e) begin
        if (takenE) begin
          ctr_q[idx_e]    <= ctr_inc;
          target_q[idx_e] <= PCTargetE;
        end else begin
          ctr_q[idx_e] <= ctr_dec;
        end
      end else if (takenE) begin
        // Miss on a taken branch evicts whatever aliases to this index.
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= PCTargetE;
        ctr_q[idx_e]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd)         branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;

endmodule
